// File: rtl/dbg_pkg.sv
// Shared types and helpers for the halt-and-dump debug unit.
// Build option DBG_DUMP_HILO_EN appends hi/lo words to the dump.
package dbg_pkg;

    typedef enum logic [1:0] {
        RUN,
        DUMP,
        DONE
    } state_e;

    localparam logic [1:0] CAUSE_NONE    = 2'b00;
    localparam logic [1:0] CAUSE_BKPT    = 2'b01;
    localparam logic [1:0] CAUSE_TIMEOUT = 2'b10;

    function automatic int nwords(input int nreg);
`ifdef DBG_DUMP_HILO_EN
        return nreg + 4;
`else
        return nreg + 2;
`endif
    endfunction

endpackage

// File: rtl/dbg_bkpt_match.sv
// Parallel PC breakpoint comparators; hit only counts on a retiring
// instruction.
module dbg_bkpt_match #(
    parameter int XLEN  = 32,
    parameter int NBKPT = 2
) (
    input  logic [XLEN-1:0]       pc_i,
    input  logic                  retire_i,
    input  logic [NBKPT*XLEN-1:0] bkpt_addr_i,
    input  logic [NBKPT-1:0]      bkpt_en_i,
    output logic                  hit_o
);

    logic match;

    always_comb begin
        match = 1'b0;
        for (int k = 0; k < NBKPT; k++) begin
            if (bkpt_en_i[k] &&
                pc_i == bkpt_addr_i[k*XLEN +: XLEN]) begin
                match = 1'b1;
            end
        end
    end

    assign hit_o = retire_i & match;

endmodule

// File: rtl/dbg_halt_dump.sv
// Halt-and-dump debug unit: stops the CPU on breakpoint/timeout, then
// streams PC, instr and the register file (hi/lo with DBG_DUMP_HILO_EN).
module dbg_halt_dump
    import dbg_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int NREG  = 32,
    parameter int AW    = 5,
    parameter int NBKPT = 2,
    parameter int CYC_W = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [XLEN-1:0]       pc_i,
    input  logic [XLEN-1:0]       instr_i,
    input  logic                  retire_i,
    input  logic [NBKPT*XLEN-1:0] bkpt_addr_i,
    input  logic [NBKPT-1:0]      bkpt_en_i,
    input  logic [CYC_W-1:0]      max_cycles_i,
    output logic                  cpu_stall_o,
    output logic [AW-1:0]         reg_sel_o,
    input  logic [XLEN-1:0]       reg_data_i,
`ifdef DBG_DUMP_HILO_EN
    input  logic [XLEN-1:0]       hi_i,
    input  logic [XLEN-1:0]       lo_i,
`endif
    output logic                  dump_valid_o,
    input  logic                  dump_ready_i,
    output logic [XLEN-1:0]       dump_data_o,
    output logic                  dump_last_o,
    output logic                  halted_o,
    output logic [1:0]            halt_cause_o,
    output logic [CYC_W-1:0]      cycle_cnt_o
);

    localparam int NW = nwords(NREG);
    localparam int WW = $clog2(NW + 1);
    localparam logic [CYC_W-1:0] CNT_MAX = {CYC_W{1'b1}};

    state_e           state_q, state_d;
    logic [XLEN-1:0]  pc_q, pc_d;
    logic [XLEN-1:0]  instr_q, instr_d;
    logic [XLEN-1:0]  data_q, data_d;
    logic [1:0]       cause_q, cause_d;
    logic [CYC_W-1:0] cnt_q, cnt_d;
    logic [WW-1:0]    widx_q, widx_d;
    logic             valid_q, valid_d;
    logic             last_q, last_d;

    logic             hit;
    logic             to;
    logic             load;
    logic             is_reg;
    logic [XLEN-1:0]  word;

    dbg_bkpt_match #(
        .XLEN  (XLEN),
        .NBKPT (NBKPT)
    ) u_match (
        .pc_i        (pc_i),
        .retire_i    (retire_i),
        .bkpt_addr_i (bkpt_addr_i),
        .bkpt_en_i   (bkpt_en_i),
        .hit_o       (hit)
    );

    assign to     = (max_cycles_i != '0) && (cnt_q == max_cycles_i);
    assign load   = !valid_q || dump_ready_i;
    assign is_reg = (widx_q >= WW'(2)) && (widx_q < WW'(NREG + 2));

    assign reg_sel_o = (state_q == DUMP && load && is_reg)
                     ? AW'(widx_q - WW'(2)) : '0;

    // rf[0] is emitted as zero whatever the register file returns
    always_comb begin
        word = '0;
        if (widx_q == WW'(0)) begin
            word = pc_q;
        end else if (widx_q == WW'(1)) begin
            word = instr_q;
        end else if (is_reg && widx_q != WW'(2)) begin
            word = reg_data_i;
`ifdef DBG_DUMP_HILO_EN
        end else if (widx_q == WW'(NREG + 2)) begin
            word = hi_i;
        end else if (widx_q == WW'(NREG + 3)) begin
            word = lo_i;
`endif
        end
    end

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        instr_d     = instr_q;
        cause_d     = cause_q;
        cnt_d       = cnt_q;
        widx_d      = widx_q;
        data_d      = data_q;
        valid_d     = valid_q;
        last_d      = last_q;
        cpu_stall_o = 1'b1;
        unique case (state_q)
            RUN: begin
                cpu_stall_o = hit || to;
                widx_d      = '0;
                if (hit || to) begin
                    state_d = DUMP;
                    pc_d    = pc_i;
                    instr_d = instr_i;
                    cause_d = hit ? CAUSE_BKPT : CAUSE_TIMEOUT;
                end else if (cnt_q != CNT_MAX) begin
                    cnt_d = cnt_q + CYC_W'(1);
                end
            end
            DUMP: begin
                if (valid_q && dump_ready_i && last_q) begin
                    state_d = DONE;
                    valid_d = 1'b0;
                    last_d  = 1'b0;
                end else if (load) begin
                    data_d  = word;
                    valid_d = 1'b1;
                    last_d  = (widx_q == WW'(NW - 1));
                    widx_d  = widx_q + WW'(1);
                end
            end
            DONE: begin
            end
            default: begin
                state_d = RUN;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= RUN;
            pc_q    <= '0;
            instr_q <= '0;
            cause_q <= CAUSE_NONE;
            cnt_q   <= '0;
            widx_q  <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
            cause_q <= cause_d;
            cnt_q   <= cnt_d;
            widx_q  <= widx_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            last_q  <= last_d;
        end
    end

    assign dump_valid_o = valid_q;
    assign dump_data_o  = data_q;
    assign dump_last_o  = last_q;
    assign halted_o     = (state_q == DONE);
    assign halt_cause_o = cause_q;
    assign cycle_cnt_o  = cnt_q;

endmodule
